// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack on a shared tri-state bus; all updates take one clock edge.
// Optional sticky stack-fault flag: define PC_STACK_ERR_EN to add the err port.
module pc_stack #(
    parameter int                WIDTH        = 16,
    parameter int                DEPTH        = 8,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    inout  wire  [WIDTH-1:0]        bus,
    input  logic                    load_bar,
    input  logic                    en_bar,
    input  logic                    inc,
    input  logic                    call,
    input  logic                    ret,
    output logic [WIDTH-1:0]        value,
    output logic [$clog2(DEPTH):0]  depth
`ifdef PC_STACK_ERR_EN
    ,
    output logic                    err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [WIDTH-1:0] r_value;
    logic [DW-1:0]    r_depth;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic [WIDTH-1:0] w_bus_in;
    logic [WIDTH-1:0] w_inc_val;
    logic [WIDTH-1:0] w_top;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_fault;
    logic [WIDTH-1:0] w_nxt_value;
    logic [DW-1:0]    w_nxt_depth;

    // While we drive the bus ourselves, a load just sees our own value.
    assign w_bus_in  = en_bar ? bus : r_value;
    assign bus       = en_bar ? {WIDTH{1'bz}} : r_value;

    assign w_inc_val = r_value + WIDTH'(1);

    // Depth equals DEPTH exactly when its top bit is set, so the low bits wrap
    // to zero and w_rd_idx lands on the last entry.
    assign w_empty   = (r_depth == '0);
    assign w_full    = r_depth[AW];
    assign w_wr_idx  = r_depth[AW-1:0];
    assign w_rd_idx  = w_wr_idx - AW'(1);
    assign w_top     = r_stack[w_rd_idx];

    always_comb begin
        w_nxt_value = r_value;
        w_nxt_depth = r_depth;
        w_push      = 1'b0;
        w_fault     = 1'b0;
        if (ret) begin
            if (w_empty) begin
                w_nxt_value = RESET_VECTOR;
                w_fault     = 1'b1;
            end else begin
                w_nxt_value = w_top;
                w_nxt_depth = r_depth - DW'(1);
            end
        end else if (call) begin
            w_nxt_value = w_bus_in;
            if (w_full) begin
                w_fault = 1'b1;
            end else begin
                w_push      = 1'b1;
                w_nxt_depth = r_depth + DW'(1);
            end
        end else if (!load_bar) begin
            w_nxt_value = w_bus_in;
        end else if (inc) begin
            w_nxt_value = w_inc_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= RESET_VECTOR;
            r_depth <= '0;
        end else begin
            r_value <= w_nxt_value;
            r_depth <= w_nxt_depth;
        end
    end

    // Stack contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_stack[w_wr_idx] <= w_inc_val;
        end
    end

    assign value = r_value;
    assign depth = r_depth;

`ifdef PC_STACK_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_fault) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_fault_unused;
    assign w_fault_unused = w_fault;
`endif

endmodule
